mac_seq_ctrl: RTL and testbench

- Sequencer that owns one combinational `mac` instance (out = a*b + c, signed) and runs a length-N dot product through it, one MAC per accepted input beat.
- Latches an initial partial sum and streams (activation, weight) pairs in over a valid/ready handshake.
- Holds the accumulated psum in a register and presents it on a valid/ready output with a sticky overflow flag.
- Sits between the activation/weight feeders and the psum collector of the PE column.

---
 rtl/mac_pkg.sv | 23 ++
 rtl/mac.sv | 18 +
 rtl/mac_seq_ctrl.sv | 109 ++++++++++
 tb/tb_mac_seq_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types, default widths and the overflow helper for the MAC sequencer.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int default_a_bw    = 2;
    localparam int default_w_bw    = 4;
    localparam int default_psum_bw = 8;
    localparam int default_cnt_bw  = 4;

    // Same result as comparing the psum_bw+1-bit exact sum with its psum_bw-bit
    // truncation: the wrapped sum can only differ when both addends share a sign
    // and the result sign flips.
    function automatic logic add_ovf(input logic prod_neg, input logic acc_neg,
                                     input logic sum_neg);
        return (prod_neg == acc_neg) && (sum_neg != acc_neg);
    endfunction

endpackage

// File: rtl/mac.sv
// Combinational signed multiply-accumulate: out = a*b + c, wrapped to psum_bw bits.
module mac #(
    parameter int a_bw    = 2,
    parameter int w_bw    = 4,
    parameter int psum_bw = 8
) (
    input  logic signed [a_bw-1:0]    a,
    input  logic signed [w_bw-1:0]    b,
    input  logic signed [psum_bw-1:0] c,
    output logic signed [psum_bw-1:0] out
);

    logic signed [a_bw+w_bw-1:0] prod;

    assign prod = a * b;
    assign out  = psum_bw'(prod) + c;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Runs a length-N dot product through one mac instance and hands the psum
// downstream with a sticky overflow flag.
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int a_bw    = default_a_bw,
    parameter int w_bw    = default_w_bw,
    parameter int psum_bw = default_psum_bw,
    parameter int cnt_bw  = default_cnt_bw
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [cnt_bw-1:0]  len,
    input  logic [psum_bw-1:0] psum_init,
    output logic               busy,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [a_bw-1:0]    in_a,
    input  logic [w_bw-1:0]    in_w,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [psum_bw-1:0] out_psum,
    output logic               out_ovf,
    output state_t             dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid/ready here are decoded purely from the registered state.

    state_t             state, state_next;
    logic [psum_bw-1:0] acc, acc_next;
    logic [cnt_bw-1:0]  cnt, cnt_next;
    logic               ovf, ovf_next;
    logic [psum_bw-1:0] mac_out;
    logic               prod_neg;
    logic               beat_ovf;

    mac #(
        .a_bw    (a_bw),
        .w_bw    (w_bw),
        .psum_bw (psum_bw)
    ) u_mac (
        .a   (in_a),
        .b   (in_w),
        .c   (acc),
        .out (mac_out)
    );

    // Sign of the exact product: negative only for opposite signs and no zero factor.
    assign prod_neg = (in_a[a_bw-1] ^ in_w[w_bw-1]) & (|in_a) & (|in_w);
    assign beat_ovf = add_ovf(prod_neg, acc[psum_bw-1], mac_out[psum_bw-1]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            ovf   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        ovf_next   = ovf;
        busy       = (state != IDLE);
        in_ready   = (state == ACC);
        out_valid  = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    acc_next   = psum_init;
                    cnt_next   = len;
                    ovf_next   = 1'b0;
                    state_next = (len != '0) ? ACC : DONE;
                end
            end
            ACC: begin
                if (in_valid) begin
                    acc_next = mac_out;
                    cnt_next = cnt - 1'b1;
                    ovf_next = ovf | beat_ovf;
                    if (cnt == cnt_bw'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The psum stays visible after the handshake until the next start reloads it.
    assign out_psum  = acc;
    assign out_ovf   = ovf;
    assign dbg_state = state;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with hand-computed expectations.
module tb_mac_seq_ctrl;
    import mac_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [3:0] len;
    logic [7:0] psum_init;
    logic       busy;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_a;
    logic [3:0] in_w;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_psum;
    logic       out_ovf;
    state_t     dbg_state;

    int checks   = 0;
    int failures = 0;

    mac_seq_ctrl #(
        .a_bw    (2),
        .w_bw    (4),
        .psum_bw (8),
        .cnt_bw  (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .len       (len),
        .psum_init (psum_init),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_psum  (out_psum),
        .out_ovf   (out_ovf),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [3:0] l, input logic [7:0] p);
        start     = 1'b1;
        len       = l;
        psum_init = p;
        tick();
        start     = 1'b0;
    endtask

    task automatic beat(input logic [1:0] a, input logic [3:0] w);
        in_valid = 1'b1;
        in_a     = a;
        in_w     = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        len       = '0;
        psum_init = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_w      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_psum", out_psum, 0);
        check("rst_out_ovf", out_ovf, 0);
        reset_n = 1'b1;
        tick();

        // Basic: 3 + 2 - 2 - 2 -> 5, 3, 1
        start_job(4'd3, 8'd3);
        check("basic_busy", busy, 1);
        check("basic_in_ready", in_ready, 1);
        beat(2'b01, 4'd2);
        check("basic_acc1", out_psum, 8'd5);
        beat(2'b11, 4'd2);
        check("basic_acc2", out_psum, 8'd3);
        check("basic_not_done", out_valid, 0);
        beat(2'b01, 4'hE);
        check("basic_acc3", out_psum, 8'd1);
        check("basic_out_valid", out_valid, 1);
        check("basic_out_ovf", out_ovf, 0);
        check("basic_in_ready_done", in_ready, 0);
        handshake();
        check("basic_idle_valid", out_valid, 0);
        check("basic_idle_busy", busy, 0);
        check("basic_psum_held", out_psum, 8'd1);

        // Both negative with a 2-cycle gap: 1 + 2 + 2 = 5
        start_job(4'd2, 8'd1);
        beat(2'b11, 4'hE);
        check("neg_acc1", out_psum, 8'd3);
        tick();
        check("neg_gap_ready1", in_ready, 1);
        tick();
        check("neg_gap_ready2", in_ready, 1);
        check("neg_gap_acc", out_psum, 8'd3);
        beat(2'b11, 4'hE);
        check("neg_out_valid", out_valid, 1);
        check("neg_out_psum", out_psum, 8'd5);
        check("neg_out_ovf", out_ovf, 0);
        handshake();

        // Overflow: 127 + 7 wraps to -122
        start_job(4'd1, 8'd127);
        beat(2'b01, 4'd7);
        check("ovf_out_valid", out_valid, 1);
        check("ovf_out_psum", out_psum, 8'h86);
        check("ovf_out_ovf", out_ovf, 1);
        handshake();
        start_job(4'd1, 8'd0);
        beat(2'b00, 4'd0);
        check("ovf_clear_valid", out_valid, 1);
        check("ovf_clear_psum", out_psum, 8'd0);
        check("ovf_clear_ovf", out_ovf, 0);
        handshake();

        // Zero length, then backpressure and an ignored start in DONE
        start_job(4'd0, 8'hFB);
        check("zero_out_valid", out_valid, 1);
        check("zero_out_psum", out_psum, 8'hFB);
        check("zero_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_out_psum", out_psum, 8'hFB);
        end
        start_job(4'd2, 8'd9);
        check("bp_start_state", dbg_state, DONE);
        check("bp_start_psum", out_psum, 8'hFB);
        check("bp_start_in_ready", in_ready, 0);
        handshake();
        check("bp_idle_busy", busy, 0);
        check("bp_idle_valid", out_valid, 0);

        // Asynchronous reset in the middle of a job
        start_job(4'd3, 8'd0);
        beat(2'b01, 4'd3);
        check("arst_acc1", out_psum, 8'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_out_psum", out_psum, 0);
        check("arst_out_ovf", out_ovf, 0);
        tick();
        reset_n = 1'b1;
        tick();
        start_job(4'd1, 8'd0);
        beat(2'b01, 4'd3);
        check("arst_new_valid", out_valid, 1);
        check("arst_new_psum", out_psum, 8'd3);
        handshake();
        check("arst_new_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
